// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers: TUSER geometry for the {tid, tkeep} packing
// and the packet-tracking state encoding used by the packer.
package axis_pkg;

   // Number of byte lanes (tkeep bits) for a given tdata width.
   function automatic int KEEP_W(input int data_w);
      return data_w / 8;
   endfunction

   // Packed tuser width: tid sits above the keep field.
   function automatic int TUSER_W(input int tid_w, input int data_w);
      return tid_w + KEEP_W(data_w);
   endfunction

   // Field offsets inside tuser. The tid offset depends on the data width,
   // so it is a function of it rather than a fixed constant.
   localparam int TUSER_KEEP_LSB = 0;

   function automatic int TUSER_TID_LSB(input int data_w);
      return KEEP_W(data_w);
   endfunction

   // FIRST: next accepted beat opens a packet; BODY: inside a packet.
   typedef enum logic {
      FIRST = 1'b0,
      BODY  = 1'b1
   } pack_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice (main + skid) with a registered ready.
// Full throughput, no combinational path from m_ready to s_ready.
module axis_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready
);

   logic             main_valid, skid_valid, ready_q;
   logic [WIDTH-1:0] main_data, skid_data;
   logic             accept, main_open;
   logic             main_valid_next, skid_valid_next;
   logic             load_main_from_skid, load_main_from_input, load_skid;

   assign accept    = s_valid & ready_q;
   assign main_open = !main_valid || m_ready;

   // Decide where the incoming beat goes and whether main refills from skid.
   always_comb begin
      // NOTE: every output gets a default first so no path through the
      // if/else leaves a signal unassigned and infers a latch.
      main_valid_next      = main_valid;
      skid_valid_next      = skid_valid;
      load_main_from_skid  = 1'b0;
      load_main_from_input = 1'b0;
      load_skid            = 1'b0;
      if (main_open) begin
         // ready_q mirrors !skid_valid, so no new beat arrives while skid holds one.
         if (skid_valid) begin
            load_main_from_skid = 1'b1;
            main_valid_next     = 1'b1;
            skid_valid_next     = 1'b0;
         end else if (accept) begin
            load_main_from_input = 1'b1;
            main_valid_next      = 1'b1;
         end else begin
            main_valid_next = 1'b0;
         end
      end else if (accept) begin
         load_skid       = 1'b1;
         skid_valid_next = 1'b1;
      end
   end

   // Occupancy flags and registered ready; ready stays low through reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         main_valid <= main_valid_next;
         skid_valid <= skid_valid_next;
         ready_q    <= !skid_valid_next;
      end
   end

   // Payload storage, qualified by the valid flags above.
   always_ff @(posedge clk) begin
      // NOTE: data registers are deliberately not reset; the valid flags
      // alone make their contents meaningful, which keeps reset fan-out low.
      if (load_main_from_skid) begin
         main_data <= skid_data;
      end else if (load_main_from_input) begin
         main_data <= s_data;
      end
      if (load_skid) begin
         skid_data <= s_data;
      end
   end

   assign s_ready = ready_q;
   assign m_valid = main_valid;
   assign m_data  = main_data;

endmodule

// File: rtl/axis_id_packer.sv
// Packs AXI-S tid/tkeep into tuser as {tid, tkeep} ahead of FIFOs and CDC
// paths that only carry tuser. Locks tid for the length of a packet,
// sanitises tkeep, flags protocol errors and counts emitted packets.
// TUSER_WIDTH must equal TID_WIDTH + DATA_WIDTH/8.
module axis_id_packer
   import axis_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int TID_WIDTH   = 2,
   parameter int TUSER_WIDTH = TUSER_W(TID_WIDTH, DATA_WIDTH),
   parameter int COUNT_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic [TID_WIDTH-1:0]      s_axis_tid,
   input  logic                      s_axis_tlast,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [TUSER_WIDTH-1:0]    m_axis_tuser,
   output logic                      m_axis_tlast,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      err_tid_mismatch,
   output logic                      err_keep,
   output logic [COUNT_WIDTH-1:0]    pkt_count
);

   localparam int KW      = KEEP_W(DATA_WIDTH);
   localparam int TID_LSB = TUSER_TID_LSB(DATA_WIDTH);
   localparam int PW      = DATA_WIDTH + TUSER_WIDTH + 1;

   pack_state_e            state, state_next;
   logic [TID_WIDTH-1:0]   tid_lock, tid_lock_next, tid_packed;
   logic [KW-1:0]          keep_packed;
   logic [TUSER_WIDTH-1:0] tuser_packed;
   logic                   accept, err_tid_next, err_keep_next;
   logic [PW-1:0]          s_payload, m_payload;

   assign accept = s_axis_tvalid & s_axis_tready;

   // Packet FSM next state, tid lock, tkeep sanitiser and error detection.
   // Nothing advances without an s-side handshake.
   always_comb begin
      state_next    = state;
      tid_lock_next = tid_lock;
      tid_packed    = tid_lock;
      keep_packed   = s_axis_tkeep;
      err_tid_next  = 1'b0;
      err_keep_next = 1'b0;

      if (state == FIRST) begin
         tid_packed = s_axis_tid;
      end

      // Only the last beat may be partial; an empty last beat is passed but flagged.
      if (!s_axis_tlast && s_axis_tkeep != '1) begin
         keep_packed   = '1;
         err_keep_next = accept;
      end else if (s_axis_tlast && s_axis_tkeep == '0) begin
         err_keep_next = accept;
      end

      if (accept) begin
         state_next = s_axis_tlast ? FIRST : BODY;
         if (state == FIRST) begin
            tid_lock_next = s_axis_tid;
         end else if (s_axis_tid != tid_lock) begin
            err_tid_next = 1'b1;
         end
      end
   end

   // Assemble tuser from its fields.
   always_comb begin
      tuser_packed                              = '0;
      tuser_packed[TUSER_KEEP_LSB +: KW]        = keep_packed;
      tuser_packed[TID_LSB +: TID_WIDTH]        = tid_packed;
   end

   assign s_payload = {s_axis_tdata, tuser_packed, s_axis_tlast};

   // FSM state, tid lock and one-cycle error pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= FIRST;
         tid_lock         <= '0;
         err_tid_mismatch <= 1'b0;
         err_keep         <= 1'b0;
      end else begin
         state            <= state_next;
         tid_lock         <= tid_lock_next;
         err_tid_mismatch <= err_tid_next;
         err_keep         <= err_keep_next;
      end
   end

   // Count packets as they leave on the master side; wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_count <= '0;
      end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
         pkt_count <= pkt_count + COUNT_WIDTH'(1);
      end
   end

   axis_skid_buffer #(
      .WIDTH (PW)
   ) u_slice (
      .clk     (clk),
      .rst     (rst),
      .s_data  (s_payload),
      .s_valid (s_axis_tvalid),
      .s_ready (s_axis_tready),
      .m_data  (m_payload),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready)
   );

   assign m_axis_tdata = m_payload[PW-1 -: DATA_WIDTH];
   assign m_axis_tuser = m_payload[TUSER_WIDTH:1];
   assign m_axis_tlast = m_payload[0];

endmodule

// File: tb/tb_axis_id_packer.sv
// Directed and random bench for axis_id_packer (64-bit data, 2-bit tid).
// A negedge monitor keeps a reference model and scoreboard; the main
// initial block drives the directed steps.
`timescale 1ns/1ps
module tb_axis_id_packer;

   localparam int DW = 64;
   localparam int KW = 8;
   localparam int IW = 2;
   localparam int UW = 10;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic [IW-1:0] s_axis_tid;
   logic          s_axis_tlast;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic [UW-1:0] m_axis_tuser;
   logic          m_axis_tlast;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          err_tid_mismatch;
   logic          err_keep;
   logic [CW-1:0] pkt_count;

   typedef struct {
      logic [DW-1:0] data;
      logic [UW-1:0] tuser;
      logic          last;
   } beat_t;

   beat_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int out_count = 0;
   int tid_err_seen = 0;
   int sent_lasts = 0;
   int low_end = 0;
   bit rand_ready = 1'b0;

   // Reference model state, owned by the monitor.
   bit            model_first = 1'b1;
   logic [IW-1:0] model_lock = '0;
   logic          exp_err_tid = 1'b0;
   logic          exp_err_keep = 1'b0;
   logic [CW-1:0] exp_count = '0;
   bit            hold_valid = 1'b0;
   beat_t         held;

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   axis_id_packer #(
      .DATA_WIDTH  (DW),
      .TID_WIDTH   (IW),
      .TUSER_WIDTH (UW),
      .COUNT_WIDTH (CW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .s_axis_tdata     (s_axis_tdata),
      .s_axis_tkeep     (s_axis_tkeep),
      .s_axis_tid       (s_axis_tid),
      .s_axis_tlast     (s_axis_tlast),
      .s_axis_tvalid    (s_axis_tvalid),
      .s_axis_tready    (s_axis_tready),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tuser     (m_axis_tuser),
      .m_axis_tlast     (m_axis_tlast),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tready    (m_axis_tready),
      .err_tid_mismatch (err_tid_mismatch),
      .err_keep         (err_keep),
      .pkt_count        (pkt_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Downstream ready: forced low until cycle low_end, then random or high.
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (cyc < low_end)   m_axis_tready = 1'b0;
         else if (rand_ready) m_axis_tready = ($urandom_range(0, 2) != 0);
         else                 m_axis_tready = 1'b1;
      end
   end

   // Monitor: checks pulses, count and stall stability, then pops outputs
   // and pushes model predictions for handshakes completing at the next edge.
   always @(negedge clk) begin
      beat_t e;
      logic  keep_bad_body;
      if (rst) begin
         sb.delete();
         model_first  = 1'b1;
         exp_err_tid  = 1'b0;
         exp_err_keep = 1'b0;
         exp_count    = '0;
         hold_valid   = 1'b0;
      end else begin
         check("err_tid_mismatch", err_tid_mismatch, exp_err_tid);
         check("err_keep", err_keep, exp_err_keep);
         check("pkt_count", pkt_count, exp_count);
         if (err_tid_mismatch) tid_err_seen++;

         if (hold_valid) begin
            check("stall_tvalid", m_axis_tvalid, 1);
            check("stall_tdata", m_axis_tdata, held.data);
            check("stall_tuser", m_axis_tuser, held.tuser);
            check("stall_tlast", m_axis_tlast, held.last);
         end
         hold_valid = m_axis_tvalid && !m_axis_tready;
         held       = '{m_axis_tdata, m_axis_tuser, m_axis_tlast};

         exp_err_tid  = 1'b0;
         exp_err_keep = 1'b0;

         if (m_axis_tvalid && m_axis_tready) begin
            check("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("out_tdata", m_axis_tdata, e.data);
               check("out_tuser", m_axis_tuser, e.tuser);
               check("out_tlast", m_axis_tlast, e.last);
               out_count++;
               if (m_axis_tlast) exp_count = exp_count + 1;
            end
         end

         if (s_axis_tvalid && s_axis_tready) begin
            keep_bad_body = !s_axis_tlast && (s_axis_tkeep != 8'hFF);
            e.data  = s_axis_tdata;
            e.last  = s_axis_tlast;
            e.tuser = {(model_first ? s_axis_tid : model_lock),
                       (keep_bad_body ? 8'hFF : s_axis_tkeep)};
            exp_err_keep = keep_bad_body || (s_axis_tlast && s_axis_tkeep == 8'h00);
            exp_err_tid  = !model_first && (s_axis_tid != model_lock);
            if (model_first) model_lock = s_axis_tid;
            model_first = s_axis_tlast;
            sb.push_back(e);
         end
      end
   end

   // Present one beat and hold it until accepted; returns just after the edge.
   task automatic send(input logic [DW-1:0] d, input logic [IW-1:0] id,
                       input logic [KW-1:0] k, input logic l);
      int n;
      s_axis_tdata  = d;
      s_axis_tid    = id;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_axis_tready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("s_ready_timeout", s_axis_tready, 1);
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      if (l) sent_lasts++;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || m_axis_tvalid) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_timeout", n < 200, 1);
   endtask

   task automatic send_random();
      logic [KW-1:0] k;
      k = ($urandom_range(0, 4) == 0) ? KW'($urandom) : 8'hFF;
      send({$urandom, $urandom}, IW'($urandom_range(0, 3)), k, ($urandom_range(0, 3) == 0));
   endtask

   initial begin
      int c0, n0, seen0;
      rst           = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tid    = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b0;

      // Reset state and ready release
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_tvalid", m_axis_tvalid, 0);
      check("rst_s_tready", s_axis_tready, 0);
      check("rst_pkt_count", pkt_count, 0);
      check("rst_err_tid", err_tid_mismatch, 0);
      check("rst_err_keep", err_keep, 0);
      rst = 1'b0;
      #1;
      check("tready_before_edge", s_axis_tready, 0);
      @(posedge clk);
      #1;
      check("tready_after_release", s_axis_tready, 1);

      // T1: single-beat packet, tid=2 keep=0x0F
      send(64'h1111_2222_3333_4444, 2'd2, 8'h0F, 1'b1);
      check("t1_tvalid", m_axis_tvalid, 1);
      check("t1_tuser", m_axis_tuser, 10'b10_00001111);
      check("t1_tlast", m_axis_tlast, 1);
      check("t1_tdata", m_axis_tdata, 64'h1111_2222_3333_4444);
      @(posedge clk);
      #1;
      check("t1_pkt_count", pkt_count, 1);

      // T2: 4-beat packet with downstream stall after beat 1
      send(64'hA1, 2'd0, 8'hFF, 1'b0);
      low_end = cyc + 3;
      send(64'hA2, 2'd0, 8'hFF, 1'b0);
      check("t2_tready_low", s_axis_tready, 0);
      send(64'hA3, 2'd0, 8'hFF, 1'b0);
      send(64'hA4, 2'd0, 8'hFF, 1'b1);
      drain();
      check("t2_pkt_count", pkt_count, 2);

      // T3: tid changes mid-packet, output stays locked
      seen0 = tid_err_seen;
      send(64'hB1, 2'd1, 8'hFF, 1'b0);
      send(64'hB2, 2'd1, 8'hFF, 1'b0);
      send(64'hB3, 2'd3, 8'hFF, 1'b0);
      check("t3_err_pulse", err_tid_mismatch, 1);
      check("t3_locked_tid", m_axis_tuser[9:8], 1);
      send(64'hB4, 2'd1, 8'hFF, 1'b1);
      check("t3_err_clear", err_tid_mismatch, 0);
      drain();
      check("t3_err_count", tid_err_seen - seen0, 1);

      // T4: tkeep sanitising
      send(64'hC1, 2'd0, 8'h0F, 1'b0);
      check("t4_keep_forced", m_axis_tuser[7:0], 8'hFF);
      check("t4_err_keep_body", err_keep, 1);
      send(64'hC2, 2'd0, 8'h00, 1'b1);
      check("t4_keep_empty_last", m_axis_tuser[7:0], 8'h00);
      check("t4_err_keep_last", err_keep, 1);
      drain();

      // T5: reset mid-packet, next packet starts clean
      send(64'hD1, 2'd1, 8'hFF, 1'b0);
      send(64'hD2, 2'd1, 8'hFF, 1'b0);
      rst = 1'b1;
      #1;
      check("t5_rst_tvalid", m_axis_tvalid, 0);
      check("t5_rst_pkt_count", pkt_count, 0);
      check("t5_rst_tready", s_axis_tready, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sent_lasts = 0;
      send(64'hE1, 2'd3, 8'hFF, 1'b0);
      check("t5_new_tid", m_axis_tuser[9:8], 3);
      send(64'hE2, 2'd3, 8'hFF, 1'b1);
      check("t5_no_mismatch", err_tid_mismatch, 0);
      drain();
      check("t5_pkt_count", pkt_count, 1);

      // T6a: 1000 back-to-back random beats, downstream always ready
      c0 = cyc;
      n0 = out_count;
      for (int i = 0; i < 1000; i++) send_random();
      @(negedge clk);
      #1;
      check("t6_out_count", out_count - n0, 1000);
      check("t6_cycles", cyc - c0, 1000);
      drain();
      check("t6_pkt_count", pkt_count, sent_lasts);

      // T6b: random beats with random downstream ready
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) send_random();
      drain();
      rand_ready = 1'b0;
      check("t6r_sb_empty", sb.size(), 0);
      check("t6r_pkt_count", pkt_count, sent_lasts);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
